fifo_ctrl: RTL and testbench
============================

// Module: fifo_ctrl
// PURPOSE
//  Synchronous single-clock FIFO: storage plus pointer/occupancy control. Generates the
//  out_is_empty/out_is_full status that producers and consumers use to gate in_write_ctrl
//  and in_read_ctrl, and that the FIFO property checker monitors. Illegal requests are
//  dropped and flagged so the FIFO tolerates a non-compliant neighbour.
// PARAMETERS
//  ENTRIES  4  depth in words; any integer >= 2, need not be a power of two
//  WIDTH    8  data word width in bits
//  CNT_W    $clog2(ENTRIES)+1 (localparam)  occupancy counter width
// PORTS
//  clk            in   1        clock; all logic on posedge
//  rst_n          in   1        synchronous reset, active low
//  in_write_ctrl  in   1        write request; in_data captured when accepted
//  in_data        in   WIDTH    write data
//  in_read_ctrl   in   1        read request
//  out_data       out  WIDTH    read data, registered
//  out_valid      out  1        1-cycle pulse: out_data updated by an accepted read
//  out_is_empty   out  1        occupancy == 0
//  out_is_full    out  1        occupancy == ENTRIES
//  out_count      out  CNT_W    current occupancy, 0..ENTRIES
//  out_overflow   out  1        1-cycle pulse: write dropped (full, no accepted read)
//  out_underflow  out  1        1-cycle pulse: read dropped (empty)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): wr_ptr=rd_ptr=0, count=0, state=S_EMPTY; out_is_empty=1,
//   out_is_full=0, out_count=0, out_data=0, out_valid=0, out_overflow=out_underflow=0.
//   Storage array not cleared. Reset mid-operation discards all contents that cycle.
//  FSM states S_EMPTY, S_PARTIAL, S_FULL; flags decoded from state (registered, no comb path
//   from inputs): out_is_empty = (state==S_EMPTY), out_is_full = (state==S_FULL).
//  Acceptance (same cycle, from current state):
//   rd_acc = in_read_ctrl & !out_is_empty
//   wr_acc = in_write_ctrl & (!out_is_full | rd_acc)
//   No write->read bypass: read in S_EMPTY is rejected even if a write is accepted.
//  Accepted write: mem[wr_ptr] <= in_data; wr_ptr wraps ENTRIES-1 -> 0.
//  Accepted read: out_data <= mem[rd_ptr] next cycle (1-cycle latency), out_valid=1 that
//   cycle; rd_ptr wraps ENTRIES-1 -> 0. out_data holds value when no read accepted.
//  Count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
//  Transitions: EMPTY->PARTIAL on wr_acc; PARTIAL->EMPTY on rd_acc only at count==1;
//   PARTIAL->FULL on wr_acc only at count==ENTRIES-1; FULL->PARTIAL on rd_acc only;
//   simultaneous rd_acc&wr_acc never changes state. Invariant: state consistent with count.
//  Errors: out_overflow=1 next cycle iff in_write_ctrl & !wr_acc; out_underflow=1 next cycle
//   iff in_read_ctrl & !rd_acc. Dropped request changes no pointer, count or state.
//  out_count never exceeds ENTRIES and never underflows; no wrap of counter permitted.
// STRUCTURE
//  fifo_pkg: typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} fifo_state_t;
//   function for pointer increment-with-wrap given ENTRIES.
//  Sub-module fifo_mem: ENTRIES x WIDTH array, one sync write port, one sync read port
//   (registered output). fifo_ctrl holds pointers, counter, FSM, error pulses.
// TESTING (ENTRIES=4, WIDTH=8)
//  Reset then idle -> out_is_empty=1, out_is_full=0, out_count=0, out_data=0, no pulses.
//  Write 0xA1,0xB2,0xC3,0xD4 -> out_is_full=1, count=4; 5th write -> out_overflow pulse,
//   count stays 4; 4 reads -> out_data A1,B2,C3,D4 each 1 cycle after read, then empty.
//  Read while empty with simultaneous write 0x55 -> out_underflow pulse, count=1, data
//   0x55 returned by next read (no bypass).
//  Full + simultaneous read&write 0xEE -> count stays 4, out_is_full stays 1, no overflow;
//   drain returns oldest-first ending in 0xEE.
//  10 write/read pairs at count=2 -> pointers wrap twice, data order preserved.
//  Fill to 3, assert rst_n=0 one cycle -> empty, count=0; next read -> out_underflow.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and helpers for the synchronous FIFO
package fifo_pkg;

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_PARTIAL = 2'd1,
        S_FULL    = 2'd2
    } fifo_state_t;

    // Advance a pointer by one, wrapping from entries-1 back to 0 (depth need not be 2^n)
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int unsigned entries);
        if (ptr == entries - 1) begin
            return 32'd0;
        end
        return ptr + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - FIFO storage array with one sync write and one registered read port
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int WIDTH   = 8,
    localparam int PTR_W  = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [ENTRIES];
    logic [WIDTH-1:0] mem_d [ENTRIES];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    // Next array contents and read register; a read of the slot being written sees the old word
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // Storage is never cleared; only the read register returns to zero on reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - synchronous FIFO: pointers, occupancy FSM, error pulses, storage
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int WIDTH   = 8,
    localparam int CNT_W  = $clog2(ENTRIES) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_write_ctrl,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_read_ctrl,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_is_empty,
    output logic             out_is_full,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overflow,
    output logic             out_underflow
);

    localparam int PTR_W = $clog2(ENTRIES);

    fifo_state_t      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             rd_acc;
    logic             wr_acc;

    // Acceptance is judged from the registered state only; a write into an empty FIFO never feeds a same-cycle read
    always_comb begin
        rd_acc = in_read_ctrl & (state_q != S_EMPTY);
        wr_acc = in_write_ctrl & ((state_q != S_FULL) | rd_acc);
    end

    // Pointer, occupancy and error-pulse next values; dropped requests leave everything untouched
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (wr_acc) begin
            wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), ENTRIES));
        end
        if (rd_acc) begin
            rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), ENTRIES));
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CNT_W'(1);
        end
        valid_d     = rd_acc;
        overflow_d  = in_write_ctrl & ~wr_acc;
        underflow_d = in_read_ctrl & ~rd_acc;
    end

    // Occupancy FSM next state; a simultaneous read and write never moves it
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_EMPTY: begin
                if (wr_acc) begin
                    state_d = S_PARTIAL;
                end
            end
            S_PARTIAL: begin
                if (rd_acc && !wr_acc && count_q == CNT_W'(1)) begin
                    state_d = S_EMPTY;
                end else if (wr_acc && !rd_acc && count_q == CNT_W'(ENTRIES - 1)) begin
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (rd_acc && !wr_acc) begin
                    state_d = S_PARTIAL;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // State register and all control flops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Status outputs decoded purely from registers
    always_comb begin
        out_is_empty  = (state_q == S_EMPTY);
        out_is_full   = (state_q == S_FULL);
        out_count     = count_q;
        out_valid     = valid_q;
        out_overflow  = overflow_q;
        out_underflow = underflow_q;
    end

    fifo_mem #(
        .ENTRIES (ENTRIES),
        .WIDTH   (WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_data (in_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr_q),
        .rd_data (out_data)
    );

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - directed self-checking bench for fifo_ctrl
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_write_ctrl;
    logic [7:0] in_data;
    logic       in_read_ctrl;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_is_empty;
    logic       out_is_full;
    logic [2:0] out_count;
    logic       out_overflow;
    logic       out_underflow;

    int total = 0;
    int bad   = 0;

    fifo_ctrl #(.ENTRIES(4), .WIDTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_write_ctrl (in_write_ctrl),
        .in_data       (in_data),
        .in_read_ctrl  (in_read_ctrl),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_is_empty  (out_is_empty),
        .out_is_full   (out_is_full),
        .out_count     (out_count),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge
    task automatic cyc(input logic w, input logic [7:0] d, input logic r);
        in_write_ctrl = w;
        in_data       = d;
        in_read_ctrl  = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag, input logic e, input logic f, input logic [2:0] c);
        check({tag, "_empty"}, 32'(out_is_empty), 32'(e));
        check({tag, "_full"},  32'(out_is_full),  32'(f));
        check({tag, "_count"}, 32'(out_count),    32'(c));
    endtask

    logic [7:0] fill_a [4];
    logic [7:0] fill_b [4];
    logic [7:0] drain_b [4];

    initial begin
        fill_a  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        fill_b  = '{8'h10, 8'h20, 8'h30, 8'h40};
        drain_b = '{8'h20, 8'h30, 8'h40, 8'hEE};

        // Reset then idle
        rst_n = 1'b0;
        cyc(0, 8'h00, 0);
        cyc(0, 8'h00, 0);
        rst_n = 1'b1;
        cyc(0, 8'h00, 0);
        check_status("rst", 1, 0, 0);
        check("rst_data",  32'(out_data),      32'h0);
        check("rst_valid", 32'(out_valid),     32'h0);
        check("rst_ovf",   32'(out_overflow),  32'h0);
        check("rst_unf",   32'(out_underflow), 32'h0);

        // Fill to full
        for (int i = 0; i < 4; i++) begin
            cyc(1, fill_a[i], 0);
            check("fill_count", 32'(out_count), 32'(i + 1));
        end
        check_status("full", 0, 1, 4);

        // Write while full is dropped
        cyc(1, 8'h99, 0);
        check("ovf_pulse", 32'(out_overflow), 32'h1);
        check("ovf_count", 32'(out_count),    32'h4);
        cyc(0, 8'h00, 0);
        check("ovf_clear", 32'(out_overflow), 32'h0);

        // Drain in order
        for (int i = 0; i < 4; i++) begin
            cyc(0, 8'h00, 1);
            check("drain_valid", 32'(out_valid), 32'h1);
            check("drain_data",  32'(out_data),  32'(fill_a[i]));
        end
        check_status("drained", 1, 0, 0);
        cyc(0, 8'h00, 0);
        check("valid_clear", 32'(out_valid), 32'h0);
        check("data_hold",   32'(out_data),  32'hD4);

        // Read while empty with simultaneous write: no bypass
        cyc(1, 8'h55, 1);
        check("nobyp_unf",   32'(out_underflow), 32'h1);
        check("nobyp_valid", 32'(out_valid),     32'h0);
        check("nobyp_count", 32'(out_count),     32'h1);
        cyc(0, 8'h00, 1);
        check("nobyp_data",  32'(out_data),      32'h55);
        check("nobyp_v2",    32'(out_valid),     32'h1);
        check("nobyp_unf2",  32'(out_underflow), 32'h0);
        check_status("nobyp", 1, 0, 0);

        // Full with simultaneous read and write
        for (int i = 0; i < 4; i++) begin
            cyc(1, fill_b[i], 0);
        end
        cyc(1, 8'hEE, 1);
        check("rw_full_ovf",  32'(out_overflow), 32'h0);
        check("rw_full_data", 32'(out_data),     32'h10);
        check_status("rw_full", 0, 1, 4);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 8'h00, 1);
            check("rw_drain", 32'(out_data), 32'(drain_b[i]));
        end
        check_status("rw_drained", 1, 0, 0);

        // Steady write/read pairs at occupancy 2 wrap the pointers
        cyc(1, 8'h01, 0);
        cyc(1, 8'h02, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 8'(i + 3), 1);
            check("pair_data",  32'(out_data),  32'(i + 1));
            check("pair_count", 32'(out_count), 32'h2);
        end
        cyc(0, 8'h00, 1);
        check("pair_tail0", 32'(out_data), 32'd11);
        cyc(0, 8'h00, 1);
        check("pair_tail1", 32'(out_data), 32'd12);
        check_status("pair_end", 1, 0, 0);

        // Reset mid-operation discards contents
        cyc(1, 8'h71, 0);
        cyc(1, 8'h72, 0);
        cyc(1, 8'h73, 0);
        check("pre_rst_count", 32'(out_count), 32'h3);
        rst_n = 1'b0;
        cyc(0, 8'h00, 0);
        rst_n = 1'b1;
        check_status("mid_rst", 1, 0, 0);
        check("mid_rst_data", 32'(out_data), 32'h0);
        cyc(0, 8'h00, 1);
        check("mid_rst_unf",   32'(out_underflow), 32'h1);
        check("mid_rst_valid", 32'(out_valid),     32'h0);
        check("mid_rst_cnt",   32'(out_count),     32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
